// File: rtl/indirect_prefetch_engine_pkg.sv
// Shared types and helpers for the indirect gather prefetch engine.
// Holds the FSM encoding and the cache-line comparison used by the filter.
package indirect_prefetch_engine_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ENC_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ENC_REQ   = 3'd1;
    localparam logic [STATE_W-1:0] ENC_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ENC_ISSUE = 3'd3;
    localparam logic [STATE_W-1:0] ENC_DONE  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_REQ   = ENC_REQ,
        ST_WAIT  = ENC_WAIT,
        ST_ISSUE = ENC_ISSUE,
        ST_DONE  = ENC_DONE
    } pf_state_e;

    // Addresses are widened to 64 bits so one helper serves any ADDR_W.
    function automatic logic line_match(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned line_bits
    );
        return (a >> line_bits) == (b >> line_bits);
    endfunction

endpackage

// File: rtl/indirect_prefetch_engine_if.sv
// Index-read and prefetch channels of the indirect prefetch engine.
// master = engine side, slave = memory / prefetch consumer side.
interface indirect_prefetch_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid;
    logic [DATA_W-1:0] rd_rsp_data;
    logic              pf_valid;
    logic              pf_ready;
    logic [ADDR_W-1:0] pf_addr;

    modport master (
        output rd_req_valid, rd_req_addr, pf_valid, pf_addr,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, pf_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, pf_valid, pf_addr,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, pf_ready
    );
endinterface

// File: rtl/indirect_prefetch_engine_pf_line_filter.sv
// Single-entry duplicate filter: remembers the last issued line.
// hit is raised when cmp_addr falls in the remembered line.
module pf_line_filter
    import indirect_prefetch_engine_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int unsigned LINE_BITS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              update,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic              hit
);
    logic [ADDR_W-1:0] line_q;
    logic              valid_q;

    // Entry is invalidated on reset/clear and loaded on each issued prefetch.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            line_q  <= '0;
            valid_q <= 1'b0;
        end else if (update) begin
            line_q  <= upd_addr;
            valid_q <= 1'b1;
        end
    end

    assign hit = valid_q &&
                 line_match(64'(cmp_addr), 64'(line_q), LINE_BITS);
endmodule

// File: rtl/indirect_prefetch_engine.sv
// Walks index array A and prefetches B[A[i]], one element at a time.
// Repeats to the most recently issued line are dropped when enabled.
module indirect_prefetch_engine
    import indirect_prefetch_engine_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          CNT_W     = 16,
    parameter int unsigned IDX_SHIFT = 2,
    parameter int unsigned LINE_BITS = 5,
    parameter bit          FILTER_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_W-1:0]           cfg_idx_base,
    input  logic [ADDR_W-1:0]           cfg_tgt_base,
    input  logic [2:0]                  cfg_elem_shift,
    input  logic [CNT_W-1:0]            cfg_count,
    indirect_prefetch_engine_if.master  bus,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  state_o,
    output logic [CNT_W-1:0]            pf_drop_cnt
);
    pf_state_e         state_q;
    logic [ADDR_W-1:0] idx_base_q;
    logic [ADDR_W-1:0] tgt_base_q;
    logic [2:0]        shift_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  i_q;
    logic              stale_q;
    logic              req_valid_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              pf_valid_q;
    logic [ADDR_W-1:0] pf_addr_q;

    logic [ADDR_W-1:0] rsp_idx;
    logic [ADDR_W-1:0] tgt;
    logic [CNT_W-1:0]  next_i;
    logic              last;
    logic [ADDR_W-1:0] next_req_addr;
    logic              filt_clear;
    logic              filt_update;
    logic              filt_hit;

    assign rsp_idx       = ADDR_W'(bus.rd_rsp_data);
    assign tgt           = tgt_base_q + (rsp_idx << shift_q);
    assign next_i        = i_q + 1'b1;
    assign last          = (next_i == count_q);
    assign next_req_addr = idx_base_q + (ADDR_W'(next_i) << IDX_SHIFT);
    assign filt_clear    = (state_q == ST_IDLE) && start;
    assign filt_update   = pf_valid_q && bus.pf_ready;

    pf_line_filter #(
        .ADDR_W    (ADDR_W),
        .LINE_BITS (LINE_BITS)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .clear    (filt_clear),
        .update   (filt_update),
        .upd_addr (pf_addr_q),
        .cmp_addr (tgt),
        .hit      (filt_hit)
    );

    // Walk FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_base_q  <= '0;
            tgt_base_q  <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            i_q         <= '0;
            stale_q     <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            pf_valid_q  <= 1'b0;
            pf_addr_q   <= '0;
            done        <= 1'b0;
            pf_drop_cnt <= '0;
        end else begin
            done <= 1'b0;
            // A response owed to an aborted walk is swallowed here.
            if (stale_q && bus.rd_rsp_valid) stale_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_base_q  <= cfg_idx_base;
                        tgt_base_q  <= cfg_tgt_base;
                        shift_q     <= cfg_elem_shift;
                        count_q     <= cfg_count;
                        i_q         <= '0;
                        pf_drop_cnt <= '0;
                        if (cfg_count == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                            req_addr_q  <= cfg_idx_base;
                        end
                    end
                end
                ST_REQ: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        req_valid_q <= 1'b0;
                        if (bus.rd_req_ready) stale_q <= 1'b1;
                    end else if (bus.rd_req_ready) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        // Our read stays owed unless it lands this cycle.
                        stale_q <= stale_q || !bus.rd_rsp_valid;
                    end else if (bus.rd_rsp_valid && !stale_q) begin
                        if (FILTER_EN && filt_hit) begin
                            if (pf_drop_cnt != '1)
                                pf_drop_cnt <= pf_drop_cnt + 1'b1;
                            i_q         <= next_i;
                            state_q     <= last ? ST_DONE : ST_REQ;
                            req_valid_q <= !last;
                            req_addr_q  <= next_req_addr;
                        end else begin
                            state_q    <= ST_ISSUE;
                            pf_valid_q <= 1'b1;
                            pf_addr_q  <= tgt;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        pf_valid_q <= 1'b0;
                    end else if (bus.pf_ready) begin
                        pf_valid_q  <= 1'b0;
                        i_q         <= next_i;
                        state_q     <= last ? ST_DONE : ST_REQ;
                        req_valid_q <= !last;
                        req_addr_q  <= next_req_addr;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (!abort) done <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_req_valid = req_valid_q;
    assign bus.rd_req_addr  = req_addr_q;
    assign bus.pf_valid     = pf_valid_q;
    assign bus.pf_addr      = pf_addr_q;
    assign busy             = (state_q != ST_IDLE);
    assign state_o          = state_q;
endmodule

// File: tb/tb_indirect_prefetch_engine.sv
// Bench for indirect_prefetch_engine: two instances, filter on and off.
// Directed vectors, corner sequences and random walks vs a gather model.
module tb_indirect_prefetch_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_idx_base = '0;
    logic [31:0] cfg_tgt_base = '0;
    logic [2:0]  cfg_elem_shift = '0;
    logic [15:0] cfg_count = '0;

    always #5 clk = ~clk;

    logic        rqv [2];
    logic [31:0] rqa [2];
    logic        pfv [2];
    logic [31:0] pfa [2];
    logic        rqr [2];
    logic        rsv [2];
    logic [31:0] rsd [2];
    logic        pfr [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic [2:0]  st_w [2];
    logic [15:0] drop_w [2];

    indirect_prefetch_engine_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    indirect_prefetch_engine_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus0.rd_req_ready = rqr[0];
    assign bus0.rd_rsp_valid = rsv[0];
    assign bus0.rd_rsp_data  = rsd[0];
    assign bus0.pf_ready     = pfr[0];
    assign rqv[0] = bus0.rd_req_valid;
    assign rqa[0] = bus0.rd_req_addr;
    assign pfv[0] = bus0.pf_valid;
    assign pfa[0] = bus0.pf_addr;
    assign bus1.rd_req_ready = rqr[1];
    assign bus1.rd_rsp_valid = rsv[1];
    assign bus1.rd_rsp_data  = rsd[1];
    assign bus1.pf_ready     = pfr[1];
    assign rqv[1] = bus1.rd_req_valid;
    assign rqa[1] = bus1.rd_req_addr;
    assign pfv[1] = bus1.pf_valid;
    assign pfa[1] = bus1.pf_addr;

    indirect_prefetch_engine #(.FILTER_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_idx_base(cfg_idx_base), .cfg_tgt_base(cfg_tgt_base),
        .cfg_elem_shift(cfg_elem_shift), .cfg_count(cfg_count),
        .bus(bus0), .busy(busy_w[0]), .done(done_w[0]),
        .state_o(st_w[0]), .pf_drop_cnt(drop_w[0])
    );

    indirect_prefetch_engine #(.FILTER_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_idx_base(cfg_idx_base), .cfg_tgt_base(cfg_tgt_base),
        .cfg_elem_shift(cfg_elem_shift), .cfg_count(cfg_count),
        .bus(bus1), .busy(busy_w[1]), .done(done_w[1]),
        .state_o(st_w[1]), .pf_drop_cnt(drop_w[1])
    );

    bit          rq_low = 1'b0;
    bit          pf_low = 1'b0;
    bit          rand_mode = 1'b0;
    int          rsp_lat = 1;
    int          cyc = 0;
    logic [31:0] mem_tab [64];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_tab[a[7:2]];
    endfunction

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    rsp_t        rsp_q [2][$];
    logic [31:0] rd_log [2][$];
    logic [31:0] pf_log [2][$];
    int          done_cnt [2];
    int          vld_cnt [2];

    // Memory, prefetch consumer and monitors for both instances.
    initial begin
        for (int g = 0; g < 2; g++) begin
            rqr[g] = 1'b0; rsv[g] = 1'b0; rsd[g] = '0; pfr[g] = 1'b0;
            done_cnt[g] = 0; vld_cnt[g] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            for (int g = 0; g < 2; g++) begin
                if (done_w[g]) done_cnt[g]++;
                if (rqv[g] || pfv[g]) vld_cnt[g]++;
                rsv[g] = 1'b0;
                if (reset) begin
                    rsp_q[g].delete();
                end else if (rsp_q[g].size() > 0 && rsp_q[g][0].due <= cyc) begin
                    rsv[g] = 1'b1;
                    rsd[g] = rsp_q[g][0].d;
                    void'(rsp_q[g].pop_front());
                end
                rqr[g] = !rq_low && (!rand_mode || $urandom_range(1, 0) == 1);
                if (rqv[g] && rqr[g] && !reset) begin
                    rd_log[g].push_back(rqa[g]);
                    rsp_q[g].push_back('{cyc + rsp_lat, mem_rd(rqa[g])});
                end
                pfr[g] = !pf_low && (!rand_mode || $urandom_range(1, 0) == 1);
                if (pfv[g] && pfr[g] && !reset) pf_log[g].push_back(pfa[g]);
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Gather model: walk A, compute B targets, drop repeats of last issued line.
    logic [31:0] exp_rd [$];
    logic [31:0] exp_pf [$];
    int          exp_drop;

    task automatic model(input logic [31:0] ib, input logic [31:0] tb,
                         input int sh, input int cnt, input bit filt);
        logic [31:0] t;
        logic [31:0] last_line;
        bit          have;
        exp_rd.delete();
        exp_pf.delete();
        exp_drop = 0;
        have = 1'b0;
        last_line = '0;
        for (int k = 0; k < cnt; k++) begin
            exp_rd.push_back(ib + 32'(k) * 4);
            t = tb + (mem_rd(ib + 32'(k) * 4) << sh);
            if (filt && have && (t >> 5) == last_line) begin
                exp_drop++;
            end else begin
                exp_pf.push_back(t);
                last_line = t >> 5;
                have = 1'b1;
            end
        end
    endtask

    int rd_b [2];
    int pf_b [2];
    int dn_b [2];
    int vl_b [2];

    // Called at a negedge; returns one negedge later with start low.
    task automatic kick(input logic [31:0] ib, input logic [31:0] tb,
                        input logic [2:0] sh, input logic [15:0] cnt);
        cfg_idx_base = ib;
        cfg_tgt_base = tb;
        cfg_elem_shift = sh;
        cfg_count = cnt;
        start = 1'b1;
        for (int g = 0; g < 2; g++) begin
            rd_b[g] = rd_log[g].size();
            pf_b[g] = pf_log[g].size();
            dn_b[g] = done_cnt[g];
            vl_b[g] = vld_cnt[g];
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int t;
        t = 0;
        while (t < 2000 && !(done_cnt[0] > dn_b[0] && done_cnt[1] > dn_b[1] &&
                             !busy_w[0] && !busy_w[1])) begin
            @(negedge clk);
            t++;
        end
        check({nm, " finish"}, 64'(t < 2000), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic cmp_walk(input string nm, input int g);
        int nrd;
        int npf;
        nrd = rd_log[g].size() - rd_b[g];
        npf = pf_log[g].size() - pf_b[g];
        check({nm, " reads"}, 64'(nrd), 64'(exp_rd.size()));
        for (int k = 0; k < nrd && k < exp_rd.size(); k++)
            check({nm, " rd_addr"}, 64'(rd_log[g][rd_b[g] + k]), 64'(exp_rd[k]));
        check({nm, " prefetches"}, 64'(npf), 64'(exp_pf.size()));
        for (int k = 0; k < npf && k < exp_pf.size(); k++)
            check({nm, " pf_addr"}, 64'(pf_log[g][pf_b[g] + k]), 64'(exp_pf[k]));
        check({nm, " drop_cnt"}, 64'(drop_w[g]), 64'(exp_drop));
        check({nm, " done_pulses"}, 64'(done_cnt[g] - dn_b[g]), 64'd1);
    endtask

    typedef struct {
        logic [31:0] ib;
        logic [31:0] tb;
        logic [2:0]  sh;
        logic [15:0] cnt;
        int          npf;
        logic [31:0] pf0;
        logic [31:0] pf1;
        int          drop;
    } vec_t;

    vec_t vt [4];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        for (int k = 0; k < 64; k++) mem_tab[k] = '0;
        mem_tab[0] = 32'd5;
        mem_tab[1] = 32'd6;
        mem_tab[2] = 32'd40;
        mem_tab[3] = 32'd8;

        vt[0] = '{32'h1000, 32'h8000, 3'd2, 16'd3, 2, 32'h8014, 32'h80A0, 1};
        vt[1] = '{32'h100C, 32'hFFFF_FFF0, 3'd2, 16'd1, 1, 32'h10, 32'h0, 0};
        vt[2] = '{32'h1000, 32'h8000, 3'd0, 16'd2, 1, 32'h8005, 32'h0, 1};
        vt[3] = '{32'h1004, 32'h8000, 3'd3, 16'd2, 2, 32'h8030, 32'h8140, 0};

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset state", 64'(st_w[g]), 64'd0);
            check("reset outputs",
                  {rqv[g], pfv[g], busy_w[g], done_w[g], rqa[g], pfa[g]}, 64'd0);
            check("reset drop_cnt", 64'(drop_w[g]), 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            kick(vt[v].ib, vt[v].tb, vt[v].sh, vt[v].cnt);
            check("first req valid", 64'(rqv[0]), 64'd1);
            check("first req addr", 64'(rqa[0]), 64'(vt[v].ib));
            wait_end("vec");
            check("vec npf", 64'(pf_log[0].size() - pf_b[0]), 64'(vt[v].npf));
            if (pf_log[0].size() > pf_b[0])
                check("vec pf0", 64'(pf_log[0][pf_b[0]]), 64'(vt[v].pf0));
            if (vt[v].npf > 1 && pf_log[0].size() > pf_b[0] + 1)
                check("vec pf1", 64'(pf_log[0][pf_b[0] + 1]), 64'(vt[v].pf1));
            check("vec drop", 64'(drop_w[0]), 64'(vt[v].drop));
            check("vec done", 64'(done_cnt[0] - dn_b[0]), 64'd1);
            model(vt[v].ib, vt[v].tb, int'(vt[v].sh), int'(vt[v].cnt), 1'b0);
            cmp_walk("nofilter vec", 1);
        end

        // count == 0: straight to DONE, done two cycles after start.
        kick(32'h1000, 32'h8000, 3'd2, 16'd0);
        check("cnt0 state DONE", 64'(st_w[0]), 64'd4);
        check("cnt0 done early", 64'(done_w[0]), 64'd0);
        @(negedge clk);
        check("cnt0 done pulse", 64'(done_w[0]), 64'd1);
        check("cnt0 back idle", 64'(st_w[0]), 64'd0);
        @(negedge clk);
        check("cnt0 done width", 64'(done_w[0]), 64'd0);
        check("cnt0 no valids", 64'(vld_cnt[0] - vl_b[0]), 64'd0);
        check("cnt0 no valids nf", 64'(vld_cnt[1] - vl_b[1]), 64'd0);
        check("cnt0 done count", 64'(done_cnt[0] - dn_b[0]), 64'd1);

        // Backpressure on both channels.
        rq_low = 1'b1;
        pf_low = 1'b1;
        kick(32'h1000, 32'h8000, 3'd2, 16'd3);
        for (int k = 0; k < 5; k++) begin
            check("bp req hold", {31'd0, rqv[0], rqa[0]}, {31'd0, 1'b1, 32'h1000});
            if (k == 4) rq_low = 1'b0;
            else @(negedge clk);
        end
        t = 0;
        while (t < 50 && !pfv[0]) begin
            @(negedge clk);
            t++;
        end
        check("bp pf seen", 64'(pfv[0]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("bp pf hold", {31'd0, pfv[0], pfa[0]}, {31'd0, 1'b1, 32'h8014});
            if (k == 3) pf_low = 1'b0;
            else @(negedge clk);
        end
        wait_end("bp");
        model(32'h1000, 32'h8000, 2, 3, 1'b1);
        cmp_walk("bp", 0);
        model(32'h1000, 32'h8000, 2, 3, 1'b0);
        cmp_walk("bp nofilter", 1);

        // Abort in WAIT with a slow memory, then restart at once.
        rsp_lat = 4;
        kick(32'h1000, 32'h8000, 3'd2, 16'd3);
        t = 0;
        while (t < 50 && st_w[0] != 3'd2) begin
            @(negedge clk);
            t++;
        end
        check("abort reached WAIT", 64'(st_w[0]), 64'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort idle", {61'd0, st_w[0]}, 64'd0);
        check("abort busy", 64'(busy_w[0]), 64'd0);
        check("abort no done", 64'(done_cnt[0] - dn_b[0]), 64'd0);
        kick(32'h1004, 32'h8000, 3'd2, 16'd1);
        wait_end("abort");
        model(32'h1004, 32'h8000, 2, 1, 1'b1);
        cmp_walk("abort restart", 0);
        model(32'h1004, 32'h8000, 2, 1, 1'b0);
        cmp_walk("abort restart nf", 1);
        rsp_lat = 1;

        // Reset while a prefetch is being held off.
        pf_low = 1'b1;
        kick(32'h1000, 32'h8000, 3'd2, 16'd3);
        t = 0;
        while (t < 50 && st_w[0] != 3'd3) begin
            @(negedge clk);
            t++;
        end
        check("rst reached ISSUE", 64'(st_w[0]), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        check("rst state", 64'(st_w[0]), 64'd0);
        check("rst outputs",
              {rqv[0], pfv[0], busy_w[0], done_w[0], rqa[0], pfa[0]}, 64'd0);
        check("rst drop_cnt", 64'(drop_w[0]), 64'd0);
        reset = 1'b0;
        pf_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst stays idle", {62'd0, rqv[0], busy_w[0]}, 64'd0);

        // Random walks against the model.
        for (int k = 0; k < 64; k++) mem_tab[k] = 32'($urandom_range(15, 0));
        rand_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [31:0] ib;
            logic [31:0] tb;
            logic [2:0]  sh;
            logic [15:0] cnt;
            ib = 32'h1000 + 32'($urandom_range(40, 0)) * 4;
            tb = $urandom;
            sh = 3'($urandom_range(7, 0));
            cnt = 16'($urandom_range(10, 0));
            rsp_lat = $urandom_range(3, 1);
            kick(ib, tb, sh, cnt);
            wait_end("rand");
            model(ib, tb, int'(sh), int'(cnt), 1'b1);
            cmp_walk("rand filter", 0);
            model(ib, tb, int'(sh), int'(cnt), 1'b0);
            cmp_walk("rand nofilter", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/indirect_prefetch_engine.md
Name: indirect_prefetch_engine

Overview:
Parametrised engine that prefetches the targets of an indirect gather loop, B[A[i]] for i = 0..count-1. On a start pulse it walks an index array through a valid/ready read port and computes each target address from the returned index. It emits one prefetch address per element, suppressing repeats to the same cache line. It sits beside the dCache and replaces the hard-coded per-loop prefetch sequencers with one configurable block.

Parameters:
ADDR_W, 32, address width; all address arithmetic is modulo 2^ADDR_W
DATA_W, 32, read-response width; the low ADDR_W bits are used as the index (zero-extended if DATA_W < ADDR_W)
CNT_W, 16, width of the element count and element counters
IDX_SHIFT, 2, log2 of the index element size in bytes
LINE_BITS, 5, log2 of the cache line size used by the duplicate filter
FILTER_EN, 1, 1 enables the same-line filter; 0 issues every element

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; captures cfg_* when idle
abort  in  1  terminates the current walk
cfg_idx_base  in  ADDR_W  base address of index array A
cfg_tgt_base  in  ADDR_W  base address of target array B
cfg_elem_shift  in  3  log2 of the target element size
cfg_count  in  CNT_W  number of elements to walk
rd_req_valid  out  1  index read request valid
rd_req_ready  in  1  memory accepts the request
rd_req_addr  out  ADDR_W  index read address
rd_rsp_valid  in  1  read data valid
rd_rsp_data  in  DATA_W  read data
pf_valid  out  1  prefetch address valid
pf_ready  in  1  prefetch consumer accepts
pf_addr  out  ADDR_W  prefetch address
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion
state_o  out  3  current FSM state, for debug
pf_drop_cnt  out  CNT_W  number of filtered elements in the current or last walk

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters cleared, filter entry invalid, stale flag cleared. Reset mid-walk returns the block to this state with no further requests issued.
- State encoding: IDLE=0, REQ=1, WAIT=2, ISSUE=3, DONE=4.
- IDLE:
  - start captures cfg_* and clears i, pf_drop_cnt and the filter.
  - cfg_count==0 goes to DONE; otherwise goes to REQ.
  - start outside IDLE is ignored.
- REQ:
  - rd_req_valid=1 with rd_req_addr = idx_base + (i << IDX_SHIFT).
  - valid and addr are held stable until rd_req_ready; on handshake go to WAIT.
  - First request is visible the cycle after start.
- WAIT:
  - On rd_rsp_valid, compute tgt = tgt_base + (idx << elem_shift) and register it.
  - If FILTER_EN and the filter is valid and tgt[ADDR_W-1:LINE_BITS] equals the stored line: pf_drop_cnt++ and advance.
  - Otherwise go to ISSUE.
- ISSUE:
  - pf_valid=1 with pf_addr=tgt, held until pf_ready.
  - On handshake, store tgt's line in the filter (mark valid) and advance.
- Advance: i++. If i+1 == count go to DONE, else go to REQ. There is no idle cycle between elements.
- DONE: done=1 for exactly one cycle, then IDLE.
- Abort in REQ, ISSUE or DONE: go to IDLE next cycle with no done pulse; valids drop that cycle.
- Abort in WAIT: go to IDLE and set the stale flag. The next rd_rsp_valid is discarded and clears the flag.
- Abort coincident with a request handshake: the request is considered issued, so the stale flag is set.
- Abort has priority over all other transitions. Abort in IDLE has no effect.
- rd_rsp_valid outside WAIT, with the stale flag clear, is ignored.
- start in IDLE while the stale flag is set is accepted; the first response is still discarded.
- Only one outstanding index read at a time.
- pf_drop_cnt saturates at all-ones.

Decomposition:
- Shared package: state enum, state-encoding constants, and a line-match function.
- One sub-module, pf_line_filter: single-entry line register, valid bit, clear, update and compare.

Test Plan:
- Basic walk. Setup: LINE_BITS=5, idx_base=0x1000, tgt_base=0x8000, elem_shift=2, count=3, memory returns 5, 6, 40. Required: reads at 0x1000, 0x1004, 0x1008; pf_addr 0x8014 then 0x80A0 (0x8018 filtered); pf_drop_cnt=1; one done pulse.
- Same walk with FILTER_EN=0: three prefetches 0x8014, 0x8018, 0x80A0; pf_drop_cnt=0.
- count=0: done pulses 2 cycles after start; no rd_req_valid or pf_valid ever asserted.
- Backpressure: rd_req_ready low for 4 cycles, then pf_ready low for 3 cycles. Required: addr and valid stable throughout; exactly one handshake each; result identical to the basic walk.
- Abort in WAIT, then start immediately: the late response 5 is discarded; the new walk's first prefetch uses its own response; no done pulse for the aborted walk.
- Wrap-around and reset. With ADDR_W=32, tgt_base=0xFFFFFFF0, idx=8, shift=2: pf_addr=0x00000010. Reset asserted mid-ISSUE: next cycle all outputs 0 and state_o=0.
